freq_calc: RTL and testbench
============================

# freq_calc

Downstream stage of the frequency-measurement path. It consumes each completed gate measurement, a ref-clock count and a sig-clock count, and computes the signal frequency in Hz as sig_cnt × REF_CLK_FREQ / ref_cnt. It uses a fixed-latency sequential restoring divider. The result is presented to the register/readout layer as a one-cycle valid strobe, a 32-bit frequency word and error flags.

## Interface
- REF_CLK_FREQ, 100_000_000, reference (clk_i) frequency in Hz; unsigned 32-bit, must be non-zero.
- clk_i  in  1  system/reference clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- meas_valid_i  in  1  one-cycle strobe: new measurement on meas_data_i.
- meas_data_i  in  64  [63:32] ref_cnt, [31:0] sig_cnt, both unsigned.
- freq_valid_o  out  1  one-cycle strobe: result on freq_data_o/freq_err_o.
- freq_data_o  out  32  frequency in Hz, unsigned; held until next result.
- freq_err_o  out  3  bit0 divide-by-zero, bit1 saturated, bit2 overrun; held with freq_data_o.
- busy_o  out  1  high while a computation is in progress.

## Operation
- FSM states: IDLE, LOAD, DIV, DONE.
- **IDLE**
  - On meas_valid_i, capture sig_cnt and ref_cnt.
  - Clear the overrun bit, then go to LOAD.
- **LOAD** (1 cycle)
  - Dividend = sig_cnt × REF_CLK_FREQ: 32×32 → 64-bit unsigned product, cannot overflow.
  - Divisor = ref_cnt, zero-extended.
  - Clear the quotient and the 33-bit partial remainder, clear the bit counter, go to DIV.
- **DIV** (exactly 64 cycles)
  - Each cycle, shift the next dividend bit (MSB first) into the remainder.
  - If remainder ≥ divisor, subtract it and shift 1 into the quotient; else shift 0.
  - When the counter reaches 63, go to DONE.
- **DONE** (1 cycle)
  - Register the outputs, pulse freq_valid_o, return to IDLE.
- **Output rules**, applied in DONE:
  - ref_cnt == 0: freq_data_o = 0, err bit0 = 1. The divider still runs, so latency is fixed.
  - Else if quotient[63:32] ≠ 0: freq_data_o = 32'hFFFF_FFFF, err bit1 = 1.
  - Else freq_data_o = quotient[31:0].
- **Overrun**
  - meas_valid_i while not in IDLE drops that measurement.
  - It sets the overrun bit, reported as err bit2 with the in-flight result.
  - No queuing.
- busy_o = 1 in LOAD, DIV and DONE; 0 in IDLE.

## Timing
- Reset values:
  - freq_valid_o = 0, freq_data_o = 0, freq_err_o = 0, busy_o = 0.
  - FSM in IDLE; all internal registers 0.
- Capture edge = cycle 0. LOAD = cycle 1, DIV = cycles 2–65, DONE = cycle 66.
- freq_valid_o is high for exactly one cycle, registered out of DONE. Capture-to-valid latency is 67 cycles.
- meas_valid_i in the DONE cycle is an overrun and is dropped.
- meas_valid_i in the cycle freq_valid_o is high is accepted, because the FSM is already in IDLE. Minimum spacing between accepted measurements is 67 cycles.
- Reset mid-computation (any state):
  - Next cycle the FSM is in IDLE and all outputs are at reset values.
  - No freq_valid_o is produced for the aborted measurement.
- Upstream gate times are ≥ 1 ms, so overrun indicates a system fault, not normal traffic.

## Configuration
- FREQ_CALC_ROUND_EN defined:
  - In LOAD, the dividend becomes sig_cnt × REF_CLK_FREQ + (ref_cnt >> 1), a 64-bit add.
  - This rounds the result to nearest, ties up.
- Not defined: the quotient is truncated toward zero.
- Latency, saturation and error behaviour are identical in both builds. The rounding add is skipped when ref_cnt == 0.

## Structure
- dfm_pkg holds:
  - typedef enum logic [1:0] freq_calc_state_t {IDLE, LOAD, DIV, DONE}.
  - Localparams FREQ_ERR_DIV0 = 0, FREQ_ERR_SAT = 1, FREQ_ERR_OVR = 2.
  - Default REF_CLK_FREQ constant, shared with the gate-time configuration.
- Sub-module seq_div_u64_u32 contains the shift/subtract datapath and the 6-bit bit counter:
  - Inputs: start, dividend[63:0], divisor[31:0].
  - Outputs: done, quotient[63:0].
- freq_calc keeps the FSM, capture, multiply, rounding and output/error logic.

## Test plan
- Nominal: REF_CLK_FREQ = 100_000_000, meas_data_i = {32'd100_000_000, 32'd1_000_000} → at cycle 67: freq_data_o = 1_000_000, freq_err_o = 0, one-cycle freq_valid_o.
- Rounding: meas_data_i = {32'd3, 32'd2} → 66_666_666 without FREQ_CALC_ROUND_EN; 66_666_667 with it; err = 0.
- Divide-by-zero: meas_data_i = {32'd0, 32'd500} → freq_data_o = 0, freq_err_o = 3'b001, still at cycle 67.
- Saturation: meas_data_i = {32'd1, 32'hFFFF_FFFF} → freq_data_o = 32'hFFFF_FFFF, freq_err_o = 3'b010.
- Overrun, then back-to-back:
  - Second meas_valid_i at cycle 10 → first result is reported with freq_err_o = 3'b100 and no second result appears.
  - Then a new meas_valid_i in the same cycle as freq_valid_o → accepted, with its result 67 cycles later.
- Reset mid-operation: assert rst_i at cycle 30 for 1 cycle → busy_o = 0 next cycle, no freq_valid_o. A subsequent measurement then completes normally.

Source files
------------

// File: rtl/dfm_pkg.sv
// Shared types and constants for the frequency-measurement path.
// Used by freq_calc and its divider; REF_CLK_FREQ default also feeds gate-time config.
package dfm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } freq_calc_state_t;

  // Bit positions inside freq_err_o
  localparam int FREQ_ERR_DIV0 = 0;
  localparam int FREQ_ERR_SAT  = 1;
  localparam int FREQ_ERR_OVR  = 2;

  localparam logic [31:0] DFM_REF_CLK_FREQ = 32'd100_000_000;

  // Clamp a 64-bit quotient into the 32-bit frequency word.
  function automatic logic [31:0] sat_u64_to_u32(input logic [63:0] value);
    return (value[63:32] != 32'd0) ? 32'hFFFF_FFFF : value[31:0];
  endfunction

endpackage

// File: rtl/freq_calc_seq_div.sv
// Fixed-latency restoring divider, 64-bit dividend by 32-bit divisor, one quotient bit per cycle.
// done is asserted during the 64th iteration; quotient is final on the following cycle.
module seq_div_u64_u32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [63:0] quotient
);

  logic [63:0] dvd_reg;
  logic [31:0] dvs_reg;
  logic [31:0] rem_reg;
  logic [63:0] quo_reg;
  logic [5:0]  cnt_reg;
  logic        active_reg;

  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        rem_ge;

  // The stored remainder is always below the divisor, so 32 bits hold it;
  // the 33-bit value only exists after shifting in the next dividend bit.
  always_comb begin
    rem_shift = {rem_reg, dvd_reg[63]};
    rem_ge    = (rem_shift >= {1'b0, dvs_reg});
    rem_sub   = rem_shift - {1'b0, dvs_reg};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      dvd_reg    <= dividend;
      dvs_reg    <= divisor;
      rem_reg    <= '0;
      quo_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      dvd_reg <= {dvd_reg[62:0], 1'b0};
      rem_reg <= rem_ge ? rem_sub[31:0] : rem_shift[31:0];
      quo_reg <= {quo_reg[62:0], rem_ge};
      cnt_reg <= cnt_reg + 6'd1;
      if (cnt_reg == 6'd63) begin
        active_reg <= 1'b0;
      end
    end
  end

  assign done     = active_reg && (cnt_reg == 6'd63);
  assign quotient = quo_reg;

endmodule

// File: rtl/freq_calc.sv
// Converts a (ref_cnt, sig_cnt) gate measurement into Hz = sig_cnt * REF_CLK_FREQ / ref_cnt.
// Optional macro FREQ_CALC_ROUND_EN: round to nearest instead of truncating.
module freq_calc
  import dfm_pkg::*;
#(
  parameter logic [31:0] REF_CLK_FREQ = DFM_REF_CLK_FREQ
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        meas_valid_i,
  input  logic [63:0] meas_data_i,
  output logic        freq_valid_o,
  output logic [31:0] freq_data_o,
  output logic [2:0]  freq_err_o,
  output logic        busy_o
);

  freq_calc_state_t state_reg, state_next;

  logic [31:0] ref_cnt_reg;
  logic [31:0] sig_cnt_reg;
  logic        ovr_reg;
  logic        freq_valid_reg;
  logic [31:0] freq_data_reg;
  logic [2:0]  freq_err_reg;

  logic        div_start;
  logic        div_done;
  logic [63:0] div_quotient;
  logic [63:0] product;
  logic [63:0] dividend;
  logic        ref_zero;
  logic [31:0] result_data;
  logic [2:0]  result_err;

  assign ref_zero  = (ref_cnt_reg == 32'd0);
  assign div_start = (state_reg == LOAD);

  // Operands are registered at capture, so the multiply has a full cycle in LOAD.
  always_comb begin
    product = 64'(sig_cnt_reg) * 64'(REF_CLK_FREQ);
`ifdef FREQ_CALC_ROUND_EN
    dividend = ref_zero ? product : (product + 64'(ref_cnt_reg >> 1));
`else
    dividend = product;
`endif
  end

  seq_div_u64_u32 u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (ref_cnt_reg),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (meas_valid_i) state_next = LOAD;
      LOAD:    state_next = DIV;
      DIV:     if (div_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A strobe arriving in DONE is also dropped, so it counts towards this result.
  always_comb begin
    result_err                = '0;
    result_err[FREQ_ERR_DIV0] = ref_zero;
    result_err[FREQ_ERR_SAT]  = !ref_zero && (div_quotient[63:32] != 32'd0);
    result_err[FREQ_ERR_OVR]  = ovr_reg || meas_valid_i;
    result_data               = ref_zero ? 32'd0 : sat_u64_to_u32(div_quotient);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      ref_cnt_reg    <= '0;
      sig_cnt_reg    <= '0;
      ovr_reg        <= 1'b0;
      freq_valid_reg <= 1'b0;
      freq_data_reg  <= '0;
      freq_err_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      freq_valid_reg <= 1'b0;
      if (meas_valid_i) begin
        if (state_reg == IDLE) begin
          ref_cnt_reg <= meas_data_i[63:32];
          sig_cnt_reg <= meas_data_i[31:0];
          ovr_reg     <= 1'b0;
        end else begin
          ovr_reg <= 1'b1;
        end
      end
      if (state_reg == DONE) begin
        freq_valid_reg <= 1'b1;
        freq_data_reg  <= result_data;
        freq_err_reg   <= result_err;
      end
    end
  end

  assign freq_valid_o = freq_valid_reg;
  assign freq_data_o  = freq_data_reg;
  assign freq_err_o   = freq_err_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_freq_calc.sv
// Scoreboard bench for freq_calc: expected {err, data} queued at stimulus, popped on freq_valid_o.
module tb_freq_calc;

  localparam logic [31:0] REF = 32'd100_000_000;
  localparam int LAT = 67;

  logic        clk = 1'b0;
  logic        rst;
  logic        meas_valid;
  logic [63:0] meas_data;
  logic        freq_valid;
  logic [31:0] freq_data;
  logic [2:0]  freq_err;
  logic        busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [34:0] exp_q[$];

  freq_calc #(.REF_CLK_FREQ(REF)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .meas_valid_i (meas_valid),
    .meas_data_i  (meas_data),
    .freq_valid_o (freq_valid),
    .freq_data_o  (freq_data),
    .freq_err_o   (freq_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [34:0] model(input logic [31:0] r, input logic [31:0] s);
    logic [63:0] p;
    logic [63:0] q;
    p = 64'(s) * 64'(REF);
`ifdef FREQ_CALC_ROUND_EN
    if (r != 0) p = p + 64'(r / 2);
`endif
    if (r == 0) return {3'b001, 32'd0};
    q = p / 64'(r);
    if (q > 64'h0000_0000_FFFF_FFFF) return {3'b010, 32'hFFFF_FFFF};
    return {3'b000, q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (freq_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Called at a sample point; returns just after the capture edge.
  task automatic issue(input logic [31:0] r, input logic [31:0] s, output int t0);
    meas_valid = 1'b1;
    meas_data  = {r, s};
    step();
    meas_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    meas_valid = 1'b0;
    meas_data = '0;
    step();
    step();
    n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", freq_valid); end
    n_checks++; if (freq_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%0d want=0", freq_data); end
    n_checks++; if (freq_err !== 3'b000) begin n_fail++; $display("FAIL reset_err got=%b want=000", freq_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_functional();
    logic [31:0] t_ref[7];
    logic [31:0] t_sig[7];
    logic [34:0] t_exp[7];
    logic [34:0] e;
    int t0;
    bit seen;
    t_ref[0] = 32'd100_000_000; t_sig[0] = 32'd1_000_000; t_exp[0] = {3'b000, 32'd1_000_000};
    t_ref[1] = 32'd3;           t_sig[1] = 32'd2;
`ifdef FREQ_CALC_ROUND_EN
    t_exp[1] = {3'b000, 32'd66_666_667};
`else
    t_exp[1] = {3'b000, 32'd66_666_666};
`endif
    t_ref[2] = 32'd0;           t_sig[2] = 32'd500;          t_exp[2] = {3'b001, 32'd0};
    t_ref[3] = 32'd1;           t_sig[3] = 32'hFFFF_FFFF;    t_exp[3] = {3'b010, 32'hFFFF_FFFF};
    for (int i = 4; i < 7; i++) begin
      t_ref[i] = $urandom_range(32'd200_000_000, 32'd1000);
      t_sig[i] = $urandom_range(t_ref[i], 32'd0);
      t_exp[i] = model(t_ref[i], t_sig[i]);
    end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(t_exp[i]);
      issue(t_ref[i], t_sig[i], t0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL func%0d_busy got=%b want=1", i, busy); end
      wait_valid(100, seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL func%0d_timeout got=no_valid want=valid", i); end
      n_checks++; if (cyc - t0 + 1 != LAT) begin n_fail++; $display("FAIL func%0d_latency got=%0d want=%0d", i, cyc - t0 + 1, LAT); end
      if (exp_q.size() == 0) e = '0; else e = exp_q.pop_front();
      $display("txn ref=%0d sig=%0d data=%0d err=%b", t_ref[i], t_sig[i], freq_data, freq_err);
      n_checks++; if (freq_data !== e[31:0]) begin n_fail++; $display("FAIL func%0d_data got=%0d want=%0d", i, freq_data, e[31:0]); end
      n_checks++; if (freq_err !== e[34:32]) begin n_fail++; $display("FAIL func%0d_err got=%b want=%b", i, freq_err, e[34:32]); end
      step();
      n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL func%0d_strobe got=%b want=0", i, freq_valid); end
      n_checks++; if (freq_data !== e[31:0]) begin n_fail++; $display("FAIL func%0d_hold got=%0d want=%0d", i, freq_data, e[31:0]); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL func%0d_idle got=%b want=0", i, busy); end
    end
  endtask

  task automatic test_overrun_back_to_back();
    logic [34:0] e;
    int t0;
    int t1;
    bit seen;
    // A: overrun strobe mid-divide
    exp_q.push_back(model(32'd100_000_000, 32'd1_000_000) | {3'b100, 32'd0});
    issue(32'd100_000_000, 32'd1_000_000, t0);
    while (cyc < t0 + 9) step();
    meas_valid = 1'b1;
    meas_data  = {32'd7, 32'd7};
    step();
    meas_valid = 1'b0;
    wait_valid(100, seen);
    n_checks++; if (!seen || cyc - t0 + 1 != LAT) begin n_fail++; $display("FAIL ovr_latency got=%0d want=%0d", cyc - t0 + 1, LAT); end
    if (exp_q.size() == 0) e = '0; else e = exp_q.pop_front();
    $display("txn ovr data=%0d err=%b", freq_data, freq_err);
    n_checks++; if (freq_data !== e[31:0]) begin n_fail++; $display("FAIL ovr_data got=%0d want=%0d", freq_data, e[31:0]); end
    n_checks++; if (freq_err !== e[34:32]) begin n_fail++; $display("FAIL ovr_err got=%b want=%b", freq_err, e[34:32]); end
    // B: issued in the freq_valid cycle, must be accepted
    exp_q.push_back(model(32'd50_000_000, 32'd12_345));
    issue(32'd50_000_000, 32'd12_345, t1);
    n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe got=%b want=0", freq_valid); end
    wait_valid(100, seen);
    n_checks++; if (!seen || cyc - t1 + 1 != LAT) begin n_fail++; $display("FAIL b2b_latency got=%0d want=%0d", cyc - t1 + 1, LAT); end
    if (exp_q.size() == 0) e = '0; else e = exp_q.pop_front();
    $display("txn b2b data=%0d err=%b", freq_data, freq_err);
    n_checks++; if (freq_data !== e[31:0]) begin n_fail++; $display("FAIL b2b_data got=%0d want=%0d", freq_data, e[31:0]); end
    n_checks++; if (freq_err !== e[34:32]) begin n_fail++; $display("FAIL b2b_err got=%b want=%b", freq_err, e[34:32]); end
    step();
    // C: strobe during the DONE cycle is an overrun and is dropped
    exp_q.push_back(model(32'd1_000, 32'd3) | {3'b100, 32'd0});
    issue(32'd1_000, 32'd3, t0);
    while (cyc < t0 + 65) step();
    meas_valid = 1'b1;
    meas_data  = {32'd9, 32'd9};
    step();
    meas_valid = 1'b0;
    n_checks++; if (freq_valid !== 1'b1) begin n_fail++; $display("FAIL done_ovr_valid got=%b want=1", freq_valid); end
    if (exp_q.size() == 0) e = '0; else e = exp_q.pop_front();
    $display("txn done_ovr data=%0d err=%b", freq_data, freq_err);
    n_checks++; if (freq_data !== e[31:0]) begin n_fail++; $display("FAIL done_ovr_data got=%0d want=%0d", freq_data, e[31:0]); end
    n_checks++; if (freq_err !== e[34:32]) begin n_fail++; $display("FAIL done_ovr_err got=%b want=%b", freq_err, e[34:32]); end
    wait_valid(80, seen);
    n_checks++; if (seen) begin n_fail++; $display("FAIL done_ovr_dropped got=extra_valid want=none"); end
  endtask

  task automatic test_reset_mid();
    logic [34:0] e;
    int t0;
    bit seen;
    issue(32'd4_000, 32'd321, t0);
    while (cyc < t0 + 29) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", freq_valid); end
    n_checks++; if (freq_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_data got=%0d want=0", freq_data); end
    n_checks++; if (freq_err !== 3'b000) begin n_fail++; $display("FAIL rstmid_err got=%b want=000", freq_err); end
    wait_valid(100, seen);
    n_checks++; if (seen) begin n_fail++; $display("FAIL rstmid_aborted got=valid want=none"); end
    exp_q.push_back(model(32'd25_000_000, 32'd777_777));
    issue(32'd25_000_000, 32'd777_777, t0);
    wait_valid(100, seen);
    n_checks++; if (!seen || cyc - t0 + 1 != LAT) begin n_fail++; $display("FAIL rstmid_latency got=%0d want=%0d", cyc - t0 + 1, LAT); end
    if (exp_q.size() == 0) e = '0; else e = exp_q.pop_front();
    $display("txn after_rst data=%0d err=%b", freq_data, freq_err);
    n_checks++; if (freq_data !== e[31:0]) begin n_fail++; $display("FAIL rstmid_data2 got=%0d want=%0d", freq_data, e[31:0]); end
    n_checks++; if (freq_err !== e[34:32]) begin n_fail++; $display("FAIL rstmid_err2 got=%b want=%b", freq_err, e[34:32]); end
  endtask

  initial begin
    test_reset();
    test_functional();
    test_overrun_back_to_back();
    test_reset_mid();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
